seq_div25x9: RTL



---
 rtl/seq_div25x9.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_div25x9.sv
// seq_div25x9: sequential restoring divider, 25-bit dividend / 9-bit divisor.
// Produces one quotient bit per clock; valid/ready handshakes on both sides.
// Divide-by-zero and quotient overflow are detected up front and retire
// one cycle after the operands are taken.
module seq_div25x9 #(
    parameter int DW_N = 25,
    parameter int DW_D = 9,
    parameter int QW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QW-1:0]   quotient,
    output logic [DW_D-1:0] remainder,
    output logic            dbz,
    output logic            ovf
);

    // The quotient only fits in QW bits if the upper dividend slice is
    // divisor-sized, which makes the overflow pre-check exact.
    if (DW_N != QW + DW_D) begin : g_bad_width
        $error("seq_div25x9: DW_N must equal QW + DW_D");
    end

    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [DW_D:0]   r_q;        // partial remainder, one guard bit
    logic [QW-1:0]   work_q;     // dividend bits out of MSB, quotient bits into LSB
    logic [DW_D-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic [QW-1:0]   quot_q;
    logic [DW_D-1:0] rem_q;
    logic            dbz_q;
    logic            ovf_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [DW_D:0]   shifted_d;
    logic [DW_D+1:0] diff_d;
    logic            take_d;
    logic [DW_D:0]   r_d;
    logic [QW-1:0]   work_d;

    // One restoring step: bring down the next dividend bit and try to subtract.
    always_comb begin
        shifted_d = {r_q[DW_D-1:0], work_q[QW-1]};
        diff_d    = {1'b0, shifted_d} - {2'b00, dvs_q};
        take_d    = ~diff_d[DW_D+1];
        r_d       = take_d ? diff_d[DW_D:0] : shifted_d;
        work_d    = {work_q[QW-2:0], take_d};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            quot_q      <= '1;
                            rem_q       <= dividend[DW_D-1:0];
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (dividend[DW_N-1:QW] >= divisor) begin
                            quot_q      <= '1;
                            rem_q       <= '0;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            r_q     <= {1'b0, dividend[DW_N-1:QW]};
                            work_q  <= dividend[QW-1:0];
                            dvs_q   <= divisor;
                            cnt_q   <= CW'(QW - 1);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q    <= r_d;
                    work_q <= work_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quot_q      <= work_d;
                        rem_q       <= r_d[DW_D-1:0];
                        dbz_q       <= 1'b0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule
